// File: rtl/encode_pkg.sv
// Shared encoding constants and request types for the RV32I instruction encoder.
// The decode stage imports this package too, so both ends agree on the class/op codes.
package encode_pkg;

  localparam logic [3:0] OPT_MATH   = 4'd0;
  localparam logic [3:0] OPT_LDST   = 4'd1;
  localparam logic [3:0] OPT_BRANCH = 4'd2;
  localparam logic [3:0] OPT_JUMP   = 4'd3;

  localparam logic [4:0] SPEC_ADD  = 5'd0;
  localparam logic [4:0] SPEC_SUB  = 5'd1;
  localparam logic [4:0] SPEC_XOR  = 5'd2;
  localparam logic [4:0] SPEC_OR   = 5'd3;
  localparam logic [4:0] SPEC_AND  = 5'd4;
  localparam logic [4:0] SPEC_SLL  = 5'd5;
  localparam logic [4:0] SPEC_SRL  = 5'd6;
  localparam logic [4:0] SPEC_SRA  = 5'd7;
  localparam logic [4:0] SPEC_SLT  = 5'd8;
  localparam logic [4:0] SPEC_SLTU = 5'd9;

  localparam logic [4:0] SPEC_LB  = 5'd0;
  localparam logic [4:0] SPEC_LH  = 5'd1;
  localparam logic [4:0] SPEC_LW  = 5'd2;
  localparam logic [4:0] SPEC_LBU = 5'd3;
  localparam logic [4:0] SPEC_LHU = 5'd4;
  localparam logic [4:0] SPEC_SB  = 5'd5;
  localparam logic [4:0] SPEC_SH  = 5'd6;
  localparam logic [4:0] SPEC_SW  = 5'd7;

  localparam logic [4:0] SPEC_BEQ  = 5'd0;
  localparam logic [4:0] SPEC_BNE  = 5'd1;
  localparam logic [4:0] SPEC_BLT  = 5'd2;
  localparam logic [4:0] SPEC_BGE  = 5'd3;
  localparam logic [4:0] SPEC_BLTU = 5'd4;
  localparam logic [4:0] SPEC_BGEU = 5'd5;

  localparam logic [4:0] SPEC_JAL  = 5'd0;
  localparam logic [4:0] SPEC_JALR = 5'd1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  op_type;
    logic [4:0]  op_spec;
    logic        use_imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } enc_req_t;

  typedef struct packed {
    logic [31:0] word;
    logic        illegal;
  } enc_entry_t;

endpackage

// File: rtl/encode_word.sv
// Combinational RV32I word assembly from a decoded request; illegal requests yield word 0.
// Build with ENCODER_STRICT_IMM_EN to also reject immediates that do not fit their field.
module encode_word
  import encode_pkg::*;
(
  input  enc_req_t    req,
  output logic [31:0] word,
  output logic        illegal
);

  logic fit_i, fit_b, fit_j, fit_sh;

`ifdef ENCODER_STRICT_IMM_EN
  // A value fits an N-bit signed field when every bit above the sign bit copies it.
  assign fit_i  = (req.imm[31:11] == '0) || (req.imm[31:11] == '1);
  assign fit_b  = ((req.imm[31:12] == '0) || (req.imm[31:12] == '1)) && !req.imm[0];
  assign fit_j  = ((req.imm[31:20] == '0) || (req.imm[31:20] == '1)) && !req.imm[0];
  assign fit_sh = (req.imm[31:5] == '0);
`else
  assign fit_i  = 1'b1;
  assign fit_b  = 1'b1;
  assign fit_j  = 1'b1;
  assign fit_sh = 1'b1;
  wire unused_imm_bits = ^{req.imm[31:21], req.imm[0]};
`endif

  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_shift;
  logic       is_store;

  always_comb begin
    word     = '0;
    illegal  = 1'b0;
    f3       = 3'b000;
    f7       = F7_ZERO;
    is_shift = 1'b0;
    is_store = 1'b0;
    case (req.op_type)
      OPT_MATH: begin
        case (req.op_spec)
          SPEC_ADD:  f3 = F3_ADD;
          SPEC_SUB:  begin f3 = F3_ADD; f7 = F7_ALT; end
          SPEC_XOR:  f3 = F3_XOR;
          SPEC_OR:   f3 = F3_OR;
          SPEC_AND:  f3 = F3_AND;
          SPEC_SLL:  begin f3 = F3_SLL; is_shift = 1'b1; end
          SPEC_SRL:  begin f3 = F3_SR;  is_shift = 1'b1; end
          SPEC_SRA:  begin f3 = F3_SR;  is_shift = 1'b1; f7 = F7_ALT; end
          SPEC_SLT:  f3 = F3_SLT;
          SPEC_SLTU: f3 = F3_SLTU;
          default:   illegal = 1'b1;
        endcase
        if (!illegal) begin
          if (!req.use_imm)
            word = {f7, req.rs2, req.rs1, f3, req.rd, OPC_OP};
          else if (req.op_spec == SPEC_SUB)
            illegal = 1'b1;
          else if (is_shift) begin
            word    = {f7, req.imm[4:0], req.rs1, f3, req.rd, OPC_OP_IMM};
            illegal = !fit_sh;
          end else begin
            word    = {req.imm[11:0], req.rs1, f3, req.rd, OPC_OP_IMM};
            illegal = !fit_i;
          end
        end
      end
      OPT_LDST: begin
        case (req.op_spec)
          SPEC_LB:  f3 = F3_B;
          SPEC_LH:  f3 = F3_H;
          SPEC_LW:  f3 = F3_W;
          SPEC_LBU: f3 = F3_BU;
          SPEC_LHU: f3 = F3_HU;
          SPEC_SB:  begin f3 = F3_B; is_store = 1'b1; end
          SPEC_SH:  begin f3 = F3_H; is_store = 1'b1; end
          SPEC_SW:  begin f3 = F3_W; is_store = 1'b1; end
          default:  illegal = 1'b1;
        endcase
        if (!illegal) begin
          if (is_store)
            word = {req.imm[11:5], req.rs2, req.rs1, f3, req.imm[4:0], OPC_STORE};
          else
            word = {req.imm[11:0], req.rs1, f3, req.rd, OPC_LOAD};
          illegal = !fit_i;
        end
      end
      OPT_BRANCH: begin
        case (req.op_spec)
          SPEC_BEQ:  f3 = F3_BEQ;
          SPEC_BNE:  f3 = F3_BNE;
          SPEC_BLT:  f3 = F3_BLT;
          SPEC_BGE:  f3 = F3_BGE;
          SPEC_BLTU: f3 = F3_BLTU;
          SPEC_BGEU: f3 = F3_BGEU;
          default:   illegal = 1'b1;
        endcase
        if (!illegal) begin
          word    = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, f3,
                     req.imm[4:1], req.imm[11], OPC_BRANCH};
          illegal = !fit_b;
        end
      end
      OPT_JUMP: begin
        case (req.op_spec)
          SPEC_JAL: begin
            word    = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                       req.rd, OPC_JAL};
            illegal = !fit_j;
          end
          SPEC_JALR: begin
            word    = {req.imm[11:0], req.rs1, F3_JALR, req.rd, OPC_JALR};
            illegal = !fit_i;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) word = '0;
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: encodes accepted requests into a DEPTH-entry output FIFO
// and counts illegal requests. ENCODER_STRICT_IMM_EN enables immediate range checking.
module instr_encoder
  import encode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op_type,
  input  logic [4:0]       in_op_spec,
  input  logic             in_use_imm,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  enc_req_t    req_p0;
  logic [31:0] enc_word_p0;
  logic        enc_illegal_p0;

  assign req_p0 = '{op_type: in_op_type, op_spec: in_op_spec, use_imm: in_use_imm,
                    rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  encode_word u_encode_word (
    .req     (req_p0),
    .word    (enc_word_p0),
    .illegal (enc_illegal_p0)
  );

  // ---- stage p1: FIFO storage ----
  enc_entry_t       mem_p1 [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             push, pop, full;

  assign full      = (occ == OCC_W'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      illegal_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      if (push && enc_illegal_p0) illegal_cnt <= sat_inc(illegal_cnt);
    end
  end

  // Storage carries no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_p1[wr_ptr] <= '{word: enc_word_p0, illegal: enc_illegal_p0};
  end

  assign out_word    = out_valid ? mem_p1[rd_ptr].word    : '0;
  assign out_illegal = out_valid ? mem_p1[rd_ptr].illegal : 1'b0;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table plus FIFO-full, saturation and reset sequences.
module tb_instr_encoder;

  logic        clk, rst;
  logic        in_valid, in_ready, in_use_imm;
  logic [3:0]  in_op_type;
  logic [4:0]  in_op_spec, in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid, out_ready, out_illegal;
  logic [31:0] out_word;
  logic [15:0] illegal_cnt;

  logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s, out_illegal_s;
  logic [31:0] out_word_s;
  logic [1:0]  illegal_cnt_s;

  instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op_type(in_op_type), .in_op_spec(in_op_spec), .in_use_imm(in_use_imm),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  instr_encoder #(.DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_op_type(in_op_type), .in_op_spec(in_op_spec), .in_use_imm(in_use_imm),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .out_word(out_word_s),
    .out_illegal(out_illegal_s), .illegal_cnt(illegal_cnt_s)
  );

  typedef struct {
    logic [3:0]  t;
    logic [4:0]  s;
    logic        ui;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] w;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    logic        ill;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t cur_exp;
  exp_t mon_e;
  vec_t vecs[14];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] t, input logic [4:0] s, input logic ui,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic [31:0] w, input logic ill);
    vec_t v;
    v.t = t; v.s = s; v.ui = ui; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.w = w; v.ill = ill;
    return v;
  endfunction

  function automatic vec_t mk_add(input logic [4:0] rd);
    return mk(4'd0, 5'd0, 1'b0, rd, 5'd1, 5'd2, 32'd0, 32'h00208033 | (32'(rd) << 7), 1'b0);
  endfunction

  // Scoreboard: expectation queued on accept, compared on pop.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pop_unexpected: got word %h, expected no entry", out_word);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_word", out_word, mon_e.w);
          chk("sb_illegal", 32'(out_illegal), 32'(mon_e.ill));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  task automatic drive(input vec_t v);
    in_op_type = v.t; in_op_spec = v.s; in_use_imm = v.ui;
    in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
    cur_exp.w = v.w; cur_exp.ill = v.ill;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v);
    logic acc;
    acc = 1'b0;
    drive(v);
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got in_ready 0, expected 1 within 50 cycles");
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int exp_ill;
    vec_t v;

    vecs[0]  = mk(4'd0, 5'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,         32'h002081B3, 1'b0);
    vecs[1]  = mk(4'd0, 5'd0, 1'b1, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF,  32'hFFF00093, 1'b0);
    vecs[2]  = mk(4'd1, 5'd7, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020A423, 1'b0);
    vecs[3]  = mk(4'd2, 5'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,  32'hFE208EE3, 1'b0);
    vecs[4]  = mk(4'd3, 5'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h001000EF, 1'b0);
    vecs[5]  = mk(4'd0, 5'd1, 1'b0, 5'd5, 5'd6, 5'd7, 32'd0,         32'h407302B3, 1'b0);
    vecs[6]  = mk(4'd0, 5'd7, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,         32'h40315093, 1'b0);
    vecs[7]  = mk(4'd1, 5'd2, 1'b0, 5'd4, 5'd2, 5'd0, 32'hFFFFFFF8,  32'hFF812203, 1'b0);
    vecs[8]  = mk(4'd3, 5'd1, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0,         32'h00008067, 1'b0);
    vecs[9]  = mk(4'd0, 5'd1, 1'b1, 5'd1, 5'd2, 5'd0, 32'd5,         32'h00000000, 1'b1);
    vecs[10] = mk(4'd2, 5'd7, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         32'h00000000, 1'b1);
    vecs[11] = mk(4'd4, 5'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0,         32'h00000000, 1'b1);
`ifdef ENCODER_STRICT_IMM_EN
    vecs[12] = mk(4'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 32'd4096,      32'h00000000, 1'b1);
`else
    vecs[12] = mk(4'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 32'd4096,      32'h00000013, 1'b0);
`endif
    vecs[13] = mk(4'd2, 5'd5, 1'b0, 5'd0, 5'd3, 5'd4, 32'd16,        32'h0041F863, 1'b0);

    rst = 1'b1; in_valid = 1'b0; in_valid_s = 1'b0; out_ready = 1'b0; out_ready_s = 1'b1;
    drive(mk_add(5'd0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    chk("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Held inputs with in_valid low must not enter the FIFO.
    repeat (2) @(posedge clk);
    #1;
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    out_ready = 1'b1;
    exp_ill = 0;
    for (int i = 0; i < 14; i++) begin
      send(vecs[i]);
      if (vecs[i].ill) exp_ill++;
      chk($sformatf("vec%0d_visible", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_word", i), out_word, vecs[i].w);
      chk($sformatf("vec%0d_illegal", i), 32'(out_illegal), 32'(vecs[i].ill));
    end
    drain();
    chk("table_illegal_cnt", 32'(illegal_cnt), 32'(exp_ill));

    // Fill to DEPTH, hold a fifth, then pop and push together.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(mk_add(5'(10 + i)));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(mk_add(5'd14));
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("held_in_ready", 32'(in_ready), 32'd0);
      chk("held_head", out_word, mk_add(5'd10).w);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("popped_in_ready", 32'(in_ready), 32'd1);
    chk("popped_head", out_word, mk_add(5'd11).w);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("pushpop_in_ready", 32'(in_ready), 32'd1);
    send(mk_add(5'd15));
    chk("refill_in_ready", 32'(in_ready), 32'd0);
    drain();

    // Saturating counter on the CNT_W=2 instance.
    drive(mk(4'd5, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1));
    in_valid_s = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sat_cnt%0d", k), 32'(illegal_cnt_s), (k > 3) ? 32'd3 : 32'(k));
      chk($sformatf("sat_head%0d", k), {out_word_s[30:0], out_illegal_s}, 32'd1);
    end
    in_valid_s = 1'b0;
    chk("sat_in_ready", 32'(in_ready_s), 32'd1);
    @(posedge clk); #1;
    chk("sat_drained", 32'(out_valid_s), 32'd0);

    // Asynchronous reset with entries pending.
    out_ready = 1'b0;
    v = mk(4'd7, 5'd3, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1);
    send(v);
    send(v);
    chk("pre_rst_cnt", 32'(illegal_cnt), 32'(exp_ill + 2));
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_word", out_word, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_cnt", 32'(illegal_cnt), 32'd0);
    chk("mid_rst_cnt_sat", 32'(illegal_cnt_s), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(vecs[0]);
    chk("post_rst_word", out_word, 32'h002081B3);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
